// File: rtl/tx_pkg.sv
// Shared types and line levels for the framed serial transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;
  localparam logic TX_STOP_LEVEL  = 1'b1;

  // Counter width for a 0..range-1 count, never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register; parallel load wins over shift.
module piso_shift_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic                  o_q0
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clear)      r_q <= '0;
    else if (i_load)  r_q <= i_d;
    else if (i_shift) r_q <= r_q >> 1;
  end

  assign o_q0 = r_q[0];

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, DATA_WIDTH bits LSB first, stop bit.
// state | meaning: IDLE ready for a byte | START line low | DATA shifting bits | STOP line high
module serial_tx
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_load,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int TIMER_W = cnt_width(CLKS_PER_BIT);
  localparam int INDEX_W = cnt_width(DATA_WIDTH);

  tx_state_t          r_state;
  tx_state_t          w_next_state;
  logic [TIMER_W-1:0] r_bit_timer;
  logic [INDEX_W-1:0] r_bit_index;
  logic               r_tx;
  logic               r_done;
  logic               w_accept;
  logic               w_bit_end;
  logic               w_last_bit;
  logic               w_shift;
  logic               w_tx_next;
  logic               w_q0;

  assign w_bit_end  = (r_bit_timer == TIMER_W'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_index == INDEX_W'(DATA_WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state     <= IDLE;
      r_bit_timer <= '0;
      r_bit_index <= '0;
      r_tx        <= TX_IDLE_LEVEL;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;
      r_done  <= (r_state == STOP) && w_bit_end;
      if (r_state == IDLE || w_bit_end) r_bit_timer <= '0;
      else                              r_bit_timer <= r_bit_timer + 1'b1;
      if (r_state == DATA && w_bit_end)
        r_bit_index <= w_last_bit ? '0 : r_bit_index + 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_accept)               w_next_state = START;
      START: if (w_bit_end)              w_next_state = DATA;
      DATA:  if (w_bit_end && w_last_bit) w_next_state = STOP;
      STOP:  if (w_bit_end)              w_next_state = IDLE;
      default:                           w_next_state = IDLE;
    endcase
  end

  // The line is registered, so each bit is fetched and the register shifted
  // at the edge where that bit begins; q0 always holds the next bit to send.
  always_comb begin
    o_ready  = (r_state == IDLE);
    o_busy   = (r_state != IDLE);
    w_accept = o_ready && i_load;
    w_shift  = w_bit_end && (r_state == START || r_state == DATA);
    case (w_next_state)
      START:   w_tx_next = TX_START_LEVEL;
      DATA:    w_tx_next = w_bit_end ? w_q0 : r_tx;
      STOP:    w_tx_next = TX_STOP_LEVEL;
      default: w_tx_next = TX_IDLE_LEVEL;
    endcase
  end

  piso_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_piso (
    .i_clk   (i_clk),
    .i_clear (i_clear),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_d     (i_data_in),
    .o_q0    (w_q0)
  );

  assign o_tx   = r_tx;
  assign o_done = r_done;

endmodule
